// File: rtl/calc_arbiter.sv
// Two-requester round-robin front end for a shared combinational calculator.
// Holds the granted operands on the ALU for ALU_WAIT cycles, then returns the result.
module calc_arbiter #(
  parameter int ALU_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [2:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic [2:0] alu_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_r,
  input  logic       alu_ovf,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [3:0] rsp_r,
  output logic       rsp_ovf,
  input  logic       rsp_ready,
  output logic [7:0] ovf_count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic       r_lastServed;
  logic       r_id;
  logic [3:0] r_waitCnt;
  logic [2:0] r_op;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_rspR;
  logic       r_rspOvf;
  logic [7:0] r_ovfCount;
  logic       w_grant;
  logic       w_xfer;
  logic       w_accept;
  logic       w_sample;

  // A lone valid requester wins outright; otherwise the one not served last is offered.
  always_comb begin
    w_nextState = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    w_grant     = (req0_valid ^ req1_valid) ? req1_valid : ~r_lastServed;
    w_xfer      = 1'b0;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = ~w_grant;
        req1_ready = w_grant;
        w_xfer     = w_grant ? req1_valid : req0_valid;
        if (w_xfer) w_nextState = ISSUE;
      end
      ISSUE: begin
        if (r_waitCnt <= 4'd1) begin
          w_sample    = 1'b1;
          w_nextState = RESP;
        end
      end
      RESP: begin
        w_accept = rsp_ready;
        if (rsp_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Operands stay on the ALU from one transfer until the next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= 3'd0;
      r_a       <= 4'd0;
      r_b       <= 4'd0;
      r_id      <= 1'b0;
      r_waitCnt <= 4'd0;
    end else if (w_xfer) begin
      r_op      <= w_grant ? req1_op : req0_op;
      r_a       <= w_grant ? req1_a  : req0_a;
      r_b       <= w_grant ? req1_b  : req0_b;
      r_id      <= w_grant;
      r_waitCnt <= 4'(ALU_WAIT);
    end else if (r_state == ISSUE && r_waitCnt != 4'd0) begin
      r_waitCnt <= r_waitCnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rspR   <= 4'd0;
      r_rspOvf <= 1'b0;
    end else if (w_sample) begin
      r_rspR   <= alu_r;
      r_rspOvf <= alu_ovf;
    end
  end

  // Round-robin history and overflow statistics only move when the consumer takes the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lastServed <= 1'b1;
      r_ovfCount   <= 8'd0;
    end else if (w_accept) begin
      r_lastServed <= r_id;
      if (r_rspOvf && r_ovfCount != 8'hFF) r_ovfCount <= r_ovfCount + 8'd1;
    end
  end

  assign alu_op    = r_op;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_r     = r_rspR;
  assign rsp_ovf   = r_rspOvf;
  assign ovf_count = r_ovfCount;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed and randomized checks of calc_arbiter against a transaction-level model,
// with a bench-side ALU that returns garbage until its operands have settled.
module tb_calc_arbiter;

  localparam int W = 3;

  logic       clk;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic [2:0] alu_op;
  logic [3:0] alu_a, alu_b, alu_r;
  logic       alu_ovf;
  logic       rsp_valid, rsp_id, rsp_ovf, rsp_ready;
  logic [3:0] rsp_r;
  logic [7:0] ovf_count;
  logic       busy;

  int   total = 0;
  int   bad = 0;
  logic mLast;
  int   mOvf;
  int   sinceXfer;
  logic [4:0] aluRes;
  logic settled;

  calc_arbiter #(.ALU_WAIT(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_ovf(rsp_ovf), .rsp_ready(rsp_ready),
    .ovf_count(ovf_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit signed calculator: add/sub flag signed overflow, logic ops never overflow.
  function automatic logic [4:0] aluCalc(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int sa, sb, s;
    logic ovf;
    logic [3:0] r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s = 0;
    ovf = 1'b0;
    r = 4'd0;
    case (op)
      3'd0: begin s = sa + sb; r = 4'(s); ovf = (s > 7) || (s < -8); end
      3'd1: begin s = sa - sb; r = 4'(s); ovf = (s > 7) || (s < -8); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a;
      3'd6: r = b;
      default: r = ~a;
    endcase
    return {ovf, r};
  endfunction

  // The external ALU only produces a correct answer once operands have been held W cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) sinceXfer <= 1000;
    else if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) sinceXfer <= 0;
    else if (sinceXfer < 1000) sinceXfer <= sinceXfer + 1;
  end

  always_comb begin
    aluRes  = aluCalc(alu_op, alu_a, alu_b);
    settled = (sinceXfer >= W - 1);
    alu_r   = aluRes[3:0] ^ (settled ? 4'h0 : 4'hA);
    alu_ovf = aluRes[4] ^ ~settled;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the arbiter idle; returns one cycle after the response is taken.
  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [2:0] op0, input logic [3:0] a0, input logic [3:0] b0,
                               input logic [2:0] op1, input logic [3:0] a1, input logic [3:0] b1,
                               input int hold);
    logic g;
    logic [2:0] eOp;
    logic [3:0] eA, eB;
    logic [4:0] eRes;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready = (hold == 0);
    #1;
    g = (v0 != v1) ? v1 : ~mLast;
    checkOutput("grant", {busy, req0_ready, req1_ready}, {1'b0, ~g, g});
    eOp  = g ? op1 : op0;
    eA   = g ? a1 : a0;
    eB   = g ? b1 : b0;
    eRes = aluCalc(eOp, eA, eB);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checkOutput("issue", {busy, rsp_valid, req0_ready, req1_ready, alu_op, alu_a, alu_b},
                  {4'b1000, eOp, eA, eB});
    end
    @(negedge clk);
    checkOutput("resp", {busy, rsp_valid, req0_ready, req1_ready, rsp_id, rsp_ovf, rsp_r},
                {4'b1100, g, eRes[4], eRes[3:0]});
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      checkOutput("resp_hold", {busy, rsp_valid, req0_ready, req1_ready, rsp_id, rsp_ovf, rsp_r},
                  {4'b1100, g, eRes[4], eRes[3:0]});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    mLast = g;
    if (eRes[4] && mOvf < 255) mOvf++;
    checkOutput("after_accept", {busy, rsp_valid, rsp_r, ovf_count}, {2'b00, eRes[3:0], 8'(mOvf)});
  endtask

  task automatic doReset();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
    checkOutput("reset_state", {busy, rsp_valid, rsp_id, rsp_ovf, rsp_r, alu_op, alu_a, alu_b, ovf_count, req0_ready, req1_ready},
                {3'b000, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 8'd0, 2'b10});
    mLast = 1'b1;
    mOvf = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req0_a = 0; req0_b = 0;
    req1_op = 0; req1_a = 0; req1_b = 0;
    rsp_ready = 0;
    mLast = 1'b1;
    mOvf = 0;
    @(negedge clk);
    doReset();

    $display("[TB] single request from requester 0");
    applyStimulus(1, 0, 3'd0, 4'd3, 4'd2, 3'd0, 4'd0, 4'd0, 0);

    $display("[TB] round robin with both requesters held valid");
    doReset();
    for (int i = 0; i < 4; i++) begin
      checkOutput("rr_order", {req0_ready, req1_ready}, (i % 2 == 0) ? 32'b10 : 32'b01);
      applyStimulus(1, 1, 3'd2, 4'(i), 4'hF, 3'd3, 4'(i), 4'h1, 0);
    end

    $display("[TB] backpressure");
    applyStimulus(1, 0, 3'd1, 4'd5, 4'd7, 3'd0, 4'd0, 4'd0, 5);

    $display("[TB] random traffic");
    for (int i = 0; i < 24; i++) begin
      logic v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(v0, v1,
                    3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3));
    end

    $display("[TB] three overflows from a clean start");
    doReset();
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 3'd0, 4'd0, 4'd0, 3'd0, 4'd7, 4'(4 + i), 0);
    checkOutput("ovf_three", ovf_count, 32'd3);

    $display("[TB] reset in the middle of an operation");
    req0_valid = 1; req0_op = 3'd0; req0_a = 4'd6; req0_b = 4'd5;
    req1_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    checkOutput("mid_busy", {busy, alu_a}, {1'b1, 4'd6});
    @(posedge clk);
    #2;
    reset = 1'b1;
    req0_valid = 0;
    req1_valid = 1;
    #1;
    checkOutput("mid_reset", {busy, rsp_valid, rsp_id, rsp_ovf, rsp_r, alu_op, alu_a, alu_b, ovf_count, req0_ready, req1_ready},
                {3'b000, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 8'd0, 2'b01});
    mLast = 1'b1;
    mOvf = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("in_reset", {busy, rsp_valid, ovf_count}, 32'd0);
    end
    reset = 1'b0;
    #1;
    checkOutput("post_reset_grant", {req0_ready, req1_ready}, 32'b01);
    applyStimulus(0, 1, 3'd0, 4'd0, 4'd0, 3'd4, 4'd9, 4'd3, 0);

    $display("[TB] overflow counter saturation");
    for (int i = 0; i < 256; i++)
      applyStimulus(1, 0, 3'd0, 4'($urandom_range(4, 7)), 4'($urandom_range(4, 7)), 3'd0, 4'd0, 4'd0, 0);
    checkOutput("ovf_saturate", ovf_count, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_arbiter.md
CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 Parameter ALU_WAIT, default 1, number of settle cycles (1..15) that operands are held on the shared ALU before the result is sampled.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester n presents an operation.
REQ-005 req0_op / req1_op  input  3 each  opcode, passed unmodified to the ALU.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  4 each  signed operands A and B.
REQ-007 req0_ready / req1_ready  output  1 each  grant; a transfer occurs on a cycle where valid and ready are both high.
REQ-008 alu_op  output  3; alu_a, alu_b  output  4 each; all drive the shared combinational calculator.
REQ-009 alu_r  input  4  signed ALU result; alu_ovf  input  1  ALU overflow flag.
REQ-010 rsp_valid  output  1; rsp_id  output  1 (requester served); rsp_r  output  4; rsp_ovf  output  1.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 ovf_count  output  8  saturating count of responses delivered with rsp_ovf=1.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, RESP; reset state IDLE.
REQ-015 In IDLE, exactly one reqN_ready SHALL be high, chosen combinationally: if only one valid, that requester; if both valid, the one not served last (round-robin); if neither valid, the one not served last.
REQ-016 Both reqN_ready SHALL be low in ISSUE and RESP.
REQ-017 On transfer, op/a/b and requester id SHALL be latched, the wait counter loaded with ALU_WAIT, and the FSM SHALL enter ISSUE on the next edge.
REQ-018 alu_op/alu_a/alu_b SHALL be driven from the latched registers in every state; they change only on a transfer.
REQ-019 In ISSUE the counter SHALL decrement each cycle; on the cycle it reads 1, alu_r and alu_ovf SHALL be registered into rsp_r/rsp_ovf and the FSM SHALL enter RESP; request-to-rsp_valid latency is therefore ALU_WAIT+1 cycles.
REQ-020 In RESP, rsp_valid SHALL be high and rsp_id/rsp_r/rsp_ovf SHALL be stable until rsp_valid and rsp_ready are both high; the FSM then returns to IDLE and last-served is updated to rsp_id.
REQ-021 No new request SHALL be accepted in the cycle the response is accepted; the earliest next transfer is the following cycle (one bubble).
REQ-022 ovf_count SHALL increment by 1 on each accepted response with rsp_ovf=1 and SHALL hold at 255.
REQ-023 rsp_valid SHALL be low outside RESP; rsp_r/rsp_ovf retain their last value.
REQ-024 Requester valid deasserting while not granted SHALL have no effect; no request is queued internally.

Reset
REQ-025 Reset SHALL immediately force: state IDLE, last-served = 1 (requester 0 wins first tie), counter 0, latched op/a/b 0, rsp_r 0, rsp_ovf 0, rsp_id 0, rsp_valid 0, ovf_count 0, busy 0.
REQ-026 Reset asserted in ISSUE or RESP SHALL abandon the operation with no response and no ovf_count update.

Verification
REQ-027 Single request: req0 op=0, a=3, b=2, ALU_WAIT=1, rsp_ready=1 -> rsp_valid 2 cycles after transfer, rsp_id=0, rsp_r=alu_r, rsp_ovf=alu_ovf.
REQ-028 Simultaneous requests held valid from reset -> grants in order 0,1,0,1; each grant one cycle after the prior response is accepted.
REQ-029 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid and rsp_r held constant, both reqN_ready low, busy high throughout.
REQ-030 Overflow: 3 responses with alu_ovf=1 -> ovf_count=3; preload to 255 then one more -> remains 255.
REQ-031 Reset mid-ISSUE with ALU_WAIT=4 -> outputs at reset values immediately, no rsp_valid; after release, req1 alone valid -> req1_ready high in IDLE.
REQ-032 ALU_WAIT=3: alu_a/alu_b stable for the 3 ISSUE cycles; rsp_r reflects alu_r sampled on the last ISSUE cycle.
